// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Conditions the raw set/up/down push buttons into clean
//               single-cycle pulses and debounced levels. Each input goes
//               through a two-flop synchronizer and a stable-count debouncer.
//               Up and down add hold-to-repeat with a first-repeat delay and
//               a repeat rate. Pressing up and down together silences both.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_set,
    input  logic btn_up,
    input  logic btn_down,
    input  logic repeat_enable,
    output logic pulsed_set,
    output logic pulsed_up,
    output logic pulsed_down,
    output logic level_set,
    output logic level_up,
    output logic level_down
);

    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_rd_last  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_rr_last  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_delay  = 2'd1;
    localparam logic [1:0] c_st_repeat = 2'd2;

    // Bit order everywhere: 0 = set, 1 = up, 2 = down.
    logic [2:0] w_btn;
    logic [2:0] w_level;
    logic [2:0] w_level_next;
    logic [1:0] w_rep_pulse;
    logic       w_conflict;
    logic       r_pulse_set;

    assign w_btn = {btn_down, btn_up, btn_set};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic             r_sync1;
        logic             r_sync2;
        logic             r_level;
        logic [CNT_W-1:0] r_cnt;
        logic             w_commit;

        // Two-flop synchronizer for the asynchronous raw button.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= w_btn[i];
                r_sync2 <= r_sync1;
            end
        end

        // Level only follows the synchronized input after it has disagreed
        // for DEBOUNCE_CYCLES consecutive cycles.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_level <= 1'b0;
                r_cnt   <= '0;
            end else if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_deb_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end

        // Next-cycle level lets pulses be registered aligned with the level.
        assign w_commit        = (r_sync2 != r_level) && (r_cnt == c_deb_last);
        assign w_level[i]      = r_level;
        assign w_level_next[i] = w_commit ? r_sync2 : r_level;
    end

    // Both up and down held (as of the coming cycle) silences both.
    assign w_conflict = w_level_next[1] & w_level_next[2];

    // Set pulse: registered rise detect, high in the first cycle level_set is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse_set <= 1'b0;
        end else begin
            r_pulse_set <= w_level_next[0] & ~w_level[0];
        end
    end

    for (genvar j = 0; j < 2; j++) begin : g_rep
        localparam int IDX = j + 1;

        logic [1:0]       r_state;
        logic [1:0]       w_state_next;
        logic [CNT_W-1:0] r_rcnt;
        logic [CNT_W-1:0] w_rcnt_next;
        logic             r_pulse;
        logic             w_pulse_next;
        logic             w_rise;
        logic             w_fall;

        assign w_rise = w_level_next[IDX] & ~w_level[IDX];
        assign w_fall = ~w_level_next[IDX] & w_level[IDX];

        // Repeat FSM state, counter and registered pulse.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_st_idle;
                r_rcnt  <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_rcnt  <= w_rcnt_next;
                r_pulse <= w_pulse_next;
            end
        end

        // Next-state: initial pulse, delay to first repeat, then periodic repeats.
        always_comb begin
            w_state_next = r_state;
            w_rcnt_next  = r_rcnt;
            w_pulse_next = 1'b0;
            if (w_fall) begin
                w_state_next = c_st_idle;
                w_rcnt_next  = '0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_rise) begin
                            w_pulse_next = 1'b1;
                            w_rcnt_next  = '0;
                            w_state_next = c_st_delay;
                        end
                    end
                    c_st_delay: begin
                        // Counter parks at its last value while repeat is disabled.
                        if (r_rcnt == c_rd_last) begin
                            if (repeat_enable) begin
                                w_pulse_next = 1'b1;
                                w_rcnt_next  = '0;
                                w_state_next = c_st_repeat;
                            end
                        end else begin
                            w_rcnt_next = r_rcnt + c_cnt_one;
                        end
                    end
                    c_st_repeat: begin
                        // Counter freezes while repeat is disabled.
                        if (repeat_enable) begin
                            if (r_rcnt == c_rr_last) begin
                                w_pulse_next = 1'b1;
                                w_rcnt_next  = '0;
                            end else begin
                                w_rcnt_next = r_rcnt + c_cnt_one;
                            end
                        end
                    end
                    default: begin
                        w_state_next = c_st_idle;
                        w_rcnt_next  = '0;
                    end
                endcase
            end
            if (w_conflict) begin
                w_state_next = c_st_idle;
                w_rcnt_next  = '0;
                w_pulse_next = 1'b0;
            end
        end

        assign w_rep_pulse[j] = r_pulse;
    end

    assign pulsed_set  = r_pulse_set;
    assign pulsed_up   = w_rep_pulse[0];
    assign pulsed_down = w_rep_pulse[1];
    assign level_set   = w_level[0];
    assign level_up    = w_level[1];
    assign level_down  = w_level[2];

endmodule
`default_nettype wire
